hasti_mem_slave: RTL and testbench

HASTI_MEM_SLAVE -- requirements
Module: hasti_mem_slave

---
 rtl/hasti_mem_slave.sv | 104 ++++++++++
 tb/tb_hasti_mem_slave.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/hasti_mem_slave.sv
// AHB-Lite (HASTI) word-organised memory slave with byte-lane writes and two-cycle ERROR responses.
// Define HASTI_MEM_WAIT_STATE_EN to insert one wait cycle ahead of every valid data phase.
module hasti_mem_slave #(
    parameter int DEPTH_LOG2 = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        io_hsel,
    input  logic [31:0] io_bus_haddr,
    input  logic        io_bus_hwrite,
    input  logic [2:0]  io_bus_hsize,
    input  logic [2:0]  io_bus_hburst,
    input  logic [3:0]  io_bus_hprot,
    input  logic        io_bus_hmastlock,
    input  logic [1:0]  io_bus_htrans,
    input  logic [31:0] io_bus_hwdata,
    output logic [31:0] io_bus_hrdata,
    output logic        io_bus_hready,
    output logic        io_bus_hresp
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic [2:0] {IDLE, DATA, WAIT, ERR1, ERR2} state_t;

`ifdef HASTI_MEM_WAIT_STATE_EN
    localparam state_t FIRST_STATE = WAIT;
`else
    localparam state_t FIRST_STATE = DATA;
`endif

    state_t                state;
    logic [31:0]           mem [DEPTH];
    logic [DEPTH_LOG2-1:0] idx_p1;
    logic                  write_p1;
    logic [3:0]            be_p1;
    logic                  accept;
    logic                  commit;
    logic                  unused_ok;

    function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] lsb);
        case (size)
            3'd0:    lane_mask = 4'b0001 << lsb;
            3'd1:    lane_mask = lsb[1] ? 4'b1100 : 4'b0011;
            default: lane_mask = 4'b1111;
        endcase
    endfunction

    function automatic logic xfer_error(input logic [2:0] size, input logic [31:0] addr);
        logic bad_size;
        logic misaligned;
        logic out_of_range;
        bad_size     = size > 3'd2;
        misaligned   = (size == 3'd1 && addr[0]) || (size == 3'd2 && addr[1:0] != 2'b00);
        out_of_range = |addr[31:DEPTH_LOG2+2];
        xfer_error   = bad_size | misaligned | out_of_range;
    endfunction

    // Reset forces the idle response immediately, even before the state register clears.
    assign io_bus_hready = reset || !(state == WAIT || state == ERR1);
    assign io_bus_hresp  = !reset && (state == ERR1 || state == ERR2);
    assign io_bus_hrdata = (!reset && state == DATA && !write_p1) ? mem[idx_p1] : 32'd0;

    assign accept = io_bus_hready && io_hsel && io_bus_htrans[1];
    assign commit = !reset && state == DATA && write_p1;

    assign unused_ok = ^{io_bus_hburst, io_bus_hprot, io_bus_hmastlock, io_bus_htrans[0]};

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            case (state)
                WAIT:    state <= DATA;
                ERR1:    state <= ERR2;
                default: begin
                    if (accept)
                        state <= xfer_error(io_bus_hsize, io_bus_haddr) ? ERR1 : FIRST_STATE;
                    else
                        state <= IDLE;
                end
            endcase
        end
    end

    // Address phase -> data phase registers
    always_ff @(posedge clk) begin
        if (accept) begin
            idx_p1   <= io_bus_haddr[DEPTH_LOG2+1:2];
            write_p1 <= io_bus_hwrite;
            be_p1    <= lane_mask(io_bus_hsize, io_bus_haddr[1:0]);
        end
    end

    // Data phase: byte-lane commit at the edge that completes the write
    always_ff @(posedge clk) begin
        if (commit) begin
            for (int b = 0; b < 4; b++) begin
                if (be_p1[b])
                    mem[idx_p1][8*b +: 8] <= io_bus_hwdata[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_hasti_mem_slave.sv
// Directed bench for hasti_mem_slave: cycle-level vector table plus reset, error and MBIST sequences.
module tb_hasti_mem_slave;
    logic        clk = 1'b0;
    logic        reset;
    logic        hsel;
    logic [31:0] haddr;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [3:0]  hprot;
    logic        hmastlock;
    logic [1:0]  htrans;
    logic [31:0] hwdata;
    logic [31:0] hrdata;
    logic        hready;
    logic        hresp;

    int checks = 0;
    int errors = 0;

`ifdef HASTI_MEM_WAIT_STATE_EN
    localparam int EXP_STALLS = 1;
`else
    localparam int EXP_STALLS = 0;
`endif

    hasti_mem_slave #(.DEPTH_LOG2(8)) dut (
        .clk              (clk),
        .reset            (reset),
        .io_hsel          (hsel),
        .io_bus_haddr     (haddr),
        .io_bus_hwrite    (hwrite),
        .io_bus_hsize     (hsize),
        .io_bus_hburst    (hburst),
        .io_bus_hprot     (hprot),
        .io_bus_hmastlock (hmastlock),
        .io_bus_htrans    (htrans),
        .io_bus_hwdata    (hwdata),
        .io_bus_hrdata    (hrdata),
        .io_bus_hready    (hready),
        .io_bus_hresp     (hresp)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        sel;
        logic [1:0]  trans;
        logic [31:0] addr;
        logic        wr;
        logic [2:0]  size;
        logic [31:0] wdata;
        logic        rdy;
        logic        resp;
        logic [31:0] rdata;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t v(input logic sel, input logic [1:0] trans, input logic [31:0] addr,
                               input logic wr, input logic [2:0] size, input logic [31:0] wdata,
                               input logic rdy, input logic resp, input logic [31:0] rdata);
        vec_t r;
        r.sel = sel; r.trans = trans; r.addr = addr; r.wr = wr; r.size = size;
        r.wdata = wdata; r.rdy = rdy; r.resp = resp; r.rdata = rdata;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        hsel = 1'b0; htrans = 2'd0; haddr = 32'd0; hwrite = 1'b0; hsize = 3'd2;
    endtask

    task automatic check_outputs(input string tag, input logic rdy, input logic resp, input logic [31:0] rd);
        check({tag, " hready"}, {31'd0, hready}, {31'd0, rdy});
        check({tag, " hresp"},  {31'd0, hresp},  {31'd0, resp});
        check({tag, " hrdata"}, hrdata, rd);
    endtask

    // One non-pipelined transfer; caller is positioned #1 after a posedge with the slave idle.
    task automatic xfer(input logic [31:0] a, input logic wr, input logic [2:0] sz, input logic [31:0] wd,
                        output logic [31:0] rd, output logic resp, output int stalls);
        hsel = 1'b1; htrans = 2'd2; haddr = a; hwrite = wr; hsize = sz;
        @(posedge clk); #1;
        drive_idle();
        hwdata = wd;
        stalls = 0;
        while (!hready && stalls < 4) begin
            stalls++;
            @(posedge clk); #1;
        end
        rd = hrdata;
        resp = hresp;
        @(posedge clk); #1;
    endtask

    logic [31:0] rd;
    logic        rsp;
    int          st;

    initial begin
        reset = 1'b1;
        hburst = 3'd0; hprot = 4'd0; hmastlock = 1'b0;
        hwdata = 32'd0;
        drive_idle();

        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            check_outputs($sformatf("reset%0d", i), 1'b1, 1'b0, 32'd0);
        end
        reset = 1'b0;

`ifndef HASTI_MEM_WAIT_STATE_EN
        // sel, trans, addr, wr, size, wdata (for the transfer in its data phase), exp rdy/resp/rdata
        vecs.push_back(v(1, 2, 32'h10,  1, 2, 32'h0,        1, 0, 32'h0));
        vecs.push_back(v(0, 0, 32'h0,   0, 2, 32'h12345678, 1, 0, 32'h0));
        vecs.push_back(v(1, 2, 32'h10,  0, 2, 32'h0,        1, 0, 32'h0));
        vecs.push_back(v(0, 0, 32'h0,   0, 2, 32'h0,        1, 0, 32'h12345678));
        vecs.push_back(v(1, 2, 32'h20,  1, 2, 32'h0,        1, 0, 32'h0));
        vecs.push_back(v(1, 2, 32'h20,  1, 0, 32'hFFFFFFFF, 1, 0, 32'h0));
        vecs.push_back(v(1, 2, 32'h22,  1, 1, 32'h000000AA, 1, 0, 32'h0));
        vecs.push_back(v(1, 2, 32'h20,  0, 2, 32'hBEEF0000, 1, 0, 32'h0));
        vecs.push_back(v(0, 0, 32'h0,   0, 2, 32'h0,        1, 0, 32'hBEEFFFAA));
        vecs.push_back(v(1, 2, 32'h0,   1, 2, 32'h0,        1, 0, 32'h0));
        vecs.push_back(v(1, 2, 32'h0,   0, 2, 32'hCAFEF00D, 1, 0, 32'h0));
        vecs.push_back(v(0, 0, 32'h0,   0, 2, 32'h0,        1, 0, 32'hCAFEF00D));
        vecs.push_back(v(0, 2, 32'h10,  1, 2, 32'h0,        1, 0, 32'h0));
        vecs.push_back(v(0, 0, 32'h0,   0, 2, 32'h0BADF00D, 1, 0, 32'h0));
        vecs.push_back(v(1, 1, 32'h10,  1, 2, 32'h0,        1, 0, 32'h0));
        vecs.push_back(v(0, 0, 32'h0,   0, 2, 32'h0BADF00D, 1, 0, 32'h0));
        vecs.push_back(v(1, 2, 32'h10,  0, 2, 32'h0,        1, 0, 32'h0));
        vecs.push_back(v(0, 0, 32'h0,   0, 2, 32'h0,        1, 0, 32'h12345678));
        vecs.push_back(v(1, 2, 32'h401, 0, 2, 32'h0,        1, 0, 32'h0));
        vecs.push_back(v(0, 0, 32'h0,   0, 2, 32'h0,        0, 1, 32'h0));
        vecs.push_back(v(0, 0, 32'h0,   0, 2, 32'h0,        1, 1, 32'h0));
        vecs.push_back(v(1, 2, 32'h400, 0, 2, 32'h0,        1, 0, 32'h0));
        vecs.push_back(v(0, 0, 32'h0,   0, 2, 32'h0,        0, 1, 32'h0));
        vecs.push_back(v(0, 0, 32'h0,   0, 2, 32'h0,        1, 1, 32'h0));
        vecs.push_back(v(1, 2, 32'h10,  1, 3, 32'h0,        1, 0, 32'h0));
        vecs.push_back(v(0, 0, 32'h0,   0, 2, 32'h22222222, 0, 1, 32'h0));
        vecs.push_back(v(1, 2, 32'h10,  1, 2, 32'h0,        1, 1, 32'h0));
        vecs.push_back(v(1, 3, 32'h11,  1, 1, 32'hFFFFFFFF, 1, 0, 32'h0));
        vecs.push_back(v(0, 0, 32'h0,   0, 2, 32'h11111111, 0, 1, 32'h0));
        vecs.push_back(v(1, 2, 32'h10,  0, 2, 32'h0,        1, 1, 32'h0));
        vecs.push_back(v(0, 0, 32'h0,   0, 2, 32'h0,        1, 0, 32'hFFFFFFFF));
        vecs.push_back(v(1, 2, 32'h400, 1, 2, 32'h0,        1, 0, 32'h0));
        vecs.push_back(v(0, 0, 32'h0,   0, 2, 32'h55555555, 0, 1, 32'h0));
        vecs.push_back(v(0, 0, 32'h0,   0, 2, 32'h0,        1, 1, 32'h0));
        vecs.push_back(v(1, 2, 32'h0,   0, 2, 32'h0,        1, 0, 32'h0));
        vecs.push_back(v(0, 0, 32'h0,   0, 2, 32'h0,        1, 0, 32'hCAFEF00D));
        vecs.push_back(v(1, 2, 32'h3FC, 1, 2, 32'h0,        1, 0, 32'h0));
        vecs.push_back(v(1, 2, 32'h3FC, 0, 2, 32'hA5A5A5A5, 1, 0, 32'h0));
        vecs.push_back(v(0, 0, 32'h0,   0, 2, 32'h0,        1, 0, 32'hA5A5A5A5));
        vecs.push_back(v(1, 2, 32'h13,  1, 0, 32'h0,        1, 0, 32'h0));
        vecs.push_back(v(1, 2, 32'h10,  1, 1, 32'h77000000, 1, 0, 32'h0));
        vecs.push_back(v(1, 2, 32'h10,  0, 2, 32'h00001234, 1, 0, 32'h0));
        vecs.push_back(v(0, 0, 32'h0,   0, 2, 32'h0,        1, 0, 32'h77FF1234));

        for (int k = 0; k < vecs.size(); k++) begin
            hsel = vecs[k].sel; htrans = vecs[k].trans; haddr = vecs[k].addr;
            hwrite = vecs[k].wr; hsize = vecs[k].size; hwdata = vecs[k].wdata;
            check_outputs($sformatf("vec%0d", k), vecs[k].rdy, vecs[k].resp, vecs[k].rdata);
            @(posedge clk); #1;
        end
        drive_idle();
`endif

        // Reset during the data phase of a write must drop the write.
        xfer(32'h8, 1'b1, 3'd2, 32'h01020304, rd, rsp, st);
        check("prewrite stalls", st, EXP_STALLS);
        hsel = 1'b1; htrans = 2'd2; haddr = 32'h8; hwrite = 1'b1; hsize = 3'd2;
        @(posedge clk); #1;
        drive_idle();
        hwdata = 32'hDEADBEEF;
        reset = 1'b1;
        #1;
        check_outputs("rst_dphase0", 1'b1, 1'b0, 32'd0);
        @(posedge clk); #1;
        check_outputs("rst_dphase1", 1'b1, 1'b0, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        xfer(32'h8, 1'b0, 3'd2, 32'h0, rd, rsp, st);
        check("rst_read data", rd, 32'h01020304);
        check("rst_read hresp", {31'd0, rsp}, 32'd0);
        check("rst_read stalls", st, EXP_STALLS);

        // Errors look the same in both builds: one stall with ERROR, then completion with ERROR.
        xfer(32'h401, 1'b0, 3'd2, 32'h0, rd, rsp, st);
        check("err_xfer stalls", st, 1);
        check("err_xfer hresp", {31'd0, rsp}, 32'd1);
        check("err_xfer hrdata", rd, 32'd0);

        // MBIST: data = word index over the whole array.
        for (int i = 0; i < 256; i++) begin
            xfer(32'(i * 4), 1'b1, 3'd2, 32'(i), rd, rsp, st);
            check($sformatf("mbist_w%0d stalls", i), st, EXP_STALLS);
            xfer(32'(i * 4), 1'b0, 3'd2, 32'h0, rd, rsp, st);
            check($sformatf("mbist_r%0d stalls", i), st, EXP_STALLS);
            check($sformatf("mbist_r%0d data", i), rd, 32'(i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
